// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - funct3 codes, LSU state encoding and store/legality helpers
package load_store_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  // Legal means a known funct3 for the direction and natural alignment for its size.
  function automatic logic access_legal(input logic is_store, input logic [2:0] f, input logic [1:0] lo);
    logic ok;
    ok = 1'b0;
    if (is_store) begin
      case (f)
        F3_SB:   ok = 1'b1;
        F3_SH:   ok = ~lo[0];
        F3_SW:   ok = (lo == 2'b00);
        default: ok = 1'b0;
      endcase
    end else begin
      case (f)
        F3_LB, F3_LBU: ok = 1'b1;
        F3_LH, F3_LHU: ok = ~lo[0];
        F3_LW:         ok = (lo == 2'b00);
        default:       ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f, input logic [1:0] lo);
    logic [3:0] be;
    case (f)
      F3_SB:   be = 4'b0001 << lo;
      F3_SH:   be = 4'b0011 << lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f, input logic [31:0] wd);
    logic [31:0] d;
    case (f)
      F3_SB:   d = {4{wd[7:0]}};
      F3_SH:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - req/ack data bus between the LSU (master) and memory (slave)
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/load_store_unit_load_align.sv
// rtl/load_store_unit_load_align.sv - load_align: byte/half/word extraction and extension of a bus word
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  f3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data = '0;
    case (f3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LW:   data = word;
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I memory stage with req/ack bus; LSU_TIMEOUT_EN adds a REQ watchdog
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
)
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_rd,
  input  logic                      mem_wr,
  input  logic [2:0]                f3,
  input  logic [31:0]               alu_res,
  input  logic [31:0]               write_data,
  output logic [31:0]               read_data,
  output logic                      stall,
  output logic                      misalign,
  output logic                      bus_err,
  load_store_unit_if.master         bus
);

  lsu_state_e  state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] rdata_q, rdata_d;

  logic        access;
  logic        legal;
  logic        timeout;
  logic [31:0] aligned;

  assign access = mem_rd | mem_wr;
  assign legal  = access_legal(mem_wr, f3, alu_res[1:0]);

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Held at zero outside REQ, so every REQ entry starts a fresh count.
  always_comb begin
    cnt_d = '0;
    if (state_q == ST_REQ) cnt_d = cnt_q + 1'b1;
  end

  assign timeout = (state_q == ST_REQ) && !bus.bus_ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err_d   = timeout;
  assign bus_err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    addr_lo_d   = addr_lo_q;
    f3_d        = f3_q;
    rdata_d     = rdata_q;
    stall       = 1'b0;
    misalign    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (legal) begin
            stall       = 1'b1;
            state_d     = ST_REQ;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_wr;
            bus_addr_d  = {alu_res[31:2], 2'b00};
            bus_be_d    = mem_wr ? store_be(f3, alu_res[1:0]) : 4'b1111;
            bus_wdata_d = mem_wr ? store_wdata(f3, write_data) : '0;
            addr_lo_d   = alu_res[1:0];
            f3_d        = f3;
            rdata_d     = '0;
          end else begin
            misalign = 1'b1;
          end
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        if (bus.bus_ack) begin
          bus_req_d = 1'b0;
          rdata_d   = bus.bus_rdata;
          state_d   = ST_DONE;
        end else if (timeout) begin
          bus_req_d = 1'b0;
          rdata_d   = '0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (rst) begin
      stall    = 1'b0;
      misalign = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= '0;
      addr_lo_q   <= 2'b00;
      f3_q        <= 3'b000;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      addr_lo_q   <= addr_lo_d;
      f3_q        <= f3_d;
      rdata_q     <= rdata_d;
    end
  end

  load_align u_load_align (
    .word    (rdata_q),
    .addr_lo (addr_lo_q),
    .f3      (f3_q),
    .data    (aligned)
  );

  // Stores retire with zero so a stale captured word never reaches the register file.
  assign read_data     = (state_q == ST_DONE && !bus_we_q) ? aligned : '0;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule
